// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache controller.
// Memory command encodings and controller state encoding.
package cache_pkg;

  localparam logic [2:0] CMD_RD_CLEAN = 3'b000;
  localparam logic [2:0] CMD_RD_DIRTY = 3'b001;
  localparam logic [2:0] CMD_WR_DIRTY = 3'b011;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    RESPOND  = 3'd5
  } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Tag/data/valid/dirty storage: combinational read by index, synchronous write.
// Latency: read 0 cycles, write visible next cycle. Backpressure: none.
// Only valid and dirty are cleared by reset; tag and data power up undefined.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_dirty
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      dirty_d[wr_idx] = wr_dirty;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back write-allocate cache controller; CACHE_STATS_EN adds hit/miss counters.
// Latency: ready 2 cycles after req on hit or clean write miss, 4 + memory latency otherwise.
// Backpressure: one request at a time; req is only sampled in IDLE, mem_done only in MEM_WAIT.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 3,
  parameter int INDEX_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              mem_start,
  output logic [2:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              ready_q, ready_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_start_q, mem_start_d;
  logic [2:0]        mem_cmd_q, mem_cmd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               arr_rd_valid, arr_rd_dirty;
  logic [TAG_W-1:0]   arr_rd_tag;
  logic [DATA_W-1:0]  arr_rd_data;
  logic               arr_wr_en, arr_wr_dirty;
  logic [DATA_W-1:0]  arr_wr_data;
  logic               line_hit, victim_dirty;

  assign req_idx      = req_addr_q[INDEX_W-1:0];
  assign req_tag      = req_addr_q[ADDR_W-1:INDEX_W];
  assign line_hit     = arr_rd_valid && (arr_rd_tag == req_tag);
  assign victim_dirty = arr_rd_valid && arr_rd_dirty;

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_idx   (req_idx),
    .rd_valid (arr_rd_valid),
    .rd_dirty (arr_rd_dirty),
    .rd_tag   (arr_rd_tag),
    .rd_data  (arr_rd_data),
    .wr_en    (arr_wr_en),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (arr_wr_data),
    .wr_dirty (arr_wr_dirty)
  );

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_we_d     = req_we_q;
    req_wdata_d  = req_wdata_q;
    fill_d       = fill_q;
    ready_d      = 1'b0;
    hit_d        = 1'b0;
    rdata_d      = rdata_q;
    mem_start_d  = 1'b0;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    arr_wr_en    = 1'b0;
    arr_wr_data  = req_wdata_q;
    arr_wr_dirty = 1'b1;

    // Outputs are computed for the state being entered so they are registered yet aligned with it.
    case (state_q)
      IDLE: begin
        if (req) begin
          req_addr_d  = addr;
          req_we_d    = we;
          req_wdata_d = wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (line_hit) begin
          hit_d   = 1'b1;
          ready_d = 1'b1;
          state_d = RESPOND;
          if (req_we_q) arr_wr_en = 1'b1;
          else          rdata_d   = arr_rd_data;
        end else if (req_we_q && !victim_dirty) begin
          arr_wr_en = 1'b1;
          ready_d   = 1'b1;
          state_d   = RESPOND;
        end else begin
          mem_cmd_d   = req_we_q     ? CMD_WR_DIRTY :
                        victim_dirty ? CMD_RD_DIRTY : CMD_RD_CLEAN;
          mem_addr_d  = req_addr_q;
          wb_addr_d   = {arr_rd_tag, req_idx};
          wb_data_d   = arr_rd_data;
          mem_start_d = 1'b1;
          state_d     = MEM_REQ;
        end
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (mem_done) begin
          fill_d  = mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        arr_wr_en = 1'b1;
        ready_d   = 1'b1;
        state_d   = RESPOND;
        if (!req_we_q) begin
          arr_wr_data  = fill_q;
          arr_wr_dirty = 1'b0;
          rdata_d      = fill_q;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      fill_q      <= '0;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      mem_start_q <= 1'b0;
      mem_cmd_q   <= '0;
      mem_addr_q  <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      fill_q      <= fill_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      rdata_q     <= rdata_d;
      mem_start_q <= mem_start_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign ready     = ready_q;
  assign hit       = hit_q;
  assign rdata     = rdata_q;
  assign mem_start = mem_start_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;

`ifdef CACHE_STATS_EN
  logic [7:0] hit_count_q, hit_count_d;
  logic [7:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == RESPOND) begin
      if (hit_q && hit_count_q != 8'hFF)         hit_count_d  = hit_count_q + 8'd1;
      else if (!hit_q && miss_count_q != 8'hFF)  miss_count_d = miss_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller.
- Sits between the CPU-side requester and the downstream memory-side mux/RAM controller.
- Decides hit or miss and, on a miss, whether the line is clean or dirty.
- Issues one command per miss on the 3-bit memory command bus, waits for the done pulse, then installs the line and answers the requester.

Parameters:
- ADDR_W, 5, address width; tag width = ADDR_W - INDEX_W.
- DATA_W, 3, width of one cache line (one word per line).
- INDEX_W, 2, index bits; line count = 2**INDEX_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  CPU request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  CPU address; sampled with req.
- wdata  in  DATA_W  CPU write data; sampled with req.
- ready  out  1  one-cycle response pulse.
- rdata  out  DATA_W  read data; valid while ready=1.
- hit  out  1  1 if the completed request hit; valid while ready=1.
- mem_start  out  1  one-cycle pulse that launches a memory command.
- mem_cmd  out  3  000 = read miss, clean; 001 = read miss, dirty; 011 = write miss, dirty.
- mem_addr  out  ADDR_W  fill address (the request address).
- wb_addr  out  ADDR_W  write-back address, {victim tag, index}.
- wb_data  out  DATA_W  victim line data.
- mem_done  in  1  one-cycle completion pulse from the memory side.
- mem_rdata  in  DATA_W  fill data; valid while mem_done=1.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All valid and dirty bits cleared; state goes to IDLE.
  - ready, hit, mem_start = 0; rdata, mem_cmd, mem_addr, wb_addr, wb_data = 0.
  - Tag and data arrays need no reset.
- State IDLE:
  - If req=1, register addr, we and wdata, then go to LOOKUP.
  - req in any other state is ignored.
- State LOOKUP: hit = valid[idx] and tag[idx]==req_tag.
  - Read hit: rdata <= data[idx]; go to RESPOND with hit=1.
  - Write hit: data[idx] <= wdata; dirty <= 1; go to RESPOND with hit=1. No memory traffic.
  - Write miss, victim clean or invalid: install tag and wdata; valid=1, dirty=1; go to RESPOND with hit=0. No memory traffic.
  - Read miss, clean: mem_cmd=000; go to MEM_REQ.
  - Read miss, dirty: mem_cmd=001; go to MEM_REQ.
  - Write miss, dirty: mem_cmd=011; go to MEM_REQ.
  - Whenever a command is issued, mem_addr, wb_addr and wb_data are loaded in this cycle.
- State MEM_REQ:
  - mem_start=1 for exactly one cycle, then go to MEM_WAIT.
  - mem_start must never be high for two consecutive cycles; the memory side re-arms on a held level.
- State MEM_WAIT:
  - mem_cmd, mem_addr, wb_addr and wb_data stay stable until mem_done.
  - On mem_done=1, go to FILL.
  - mem_done in any other state is ignored. This includes a stale done after a mid-operation reset.
- State FILL:
  - Read miss: tag, data <= mem_rdata (captured on the mem_done edge); valid=1, dirty=0; rdata <= captured data.
  - Write miss dirty: tag, data <= wdata; valid=1, dirty=1.
  - Go to RESPOND with hit=0.
- State RESPOND: ready=1 for one cycle, then go to IDLE.
  - The requester must drop req in the cycle it sees ready.
  - A req still high in the following IDLE cycle is treated as a new request.
- Latency:
  - Hit, or write miss to a clean victim: ready is high 2 cycles after the req sample edge.
  - Miss with a memory command: 4 cycles plus memory latency (from mem_start to mem_done).
- Address split: idx = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W].
- Only one request is outstanding at a time. No hit-under-miss.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count[7:0] and miss_count[7:0].
  - Each counter increments once per completed request, in the RESPOND cycle, according to hit.
  - Counters saturate at 255 and are cleared by reset_n.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package cache_pkg holds:
  - the mem_cmd localparams CMD_RD_CLEAN=3'b000, CMD_RD_DIRTY=3'b001, CMD_WR_DIRTY=3'b011;
  - the state encoding for IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESPOND.
- One sub-module, cache_line_array:
  - holds the tag, data, valid and dirty storage;
  - provides a combinational read by index and a synchronous write;
  - provides an asynchronous clear of valid and dirty.

Test Plan:
1. After reset, read addr=5'b00110 -> mem_cmd=000, mem_addr=00110, one mem_start pulse. mem_done with mem_rdata=3'b101 -> ready=1, hit=0, rdata=101.
2. Repeat the read of 00110 -> ready 2 cycles after req, hit=1, rdata=101, mem_start stays 0.
3. Write 00110 data 3'b010 (hit) -> hit=1, no memory traffic. Then read 01010 (same idx, different tag) -> mem_cmd=001, wb_addr=00110, wb_data=010, mem_addr=01010.
4. Write miss to 11110 with dirty victim data=3'b011 at 01110 -> mem_cmd=011, wb_addr=01110, wb_data=011. After mem_done, read 11110 hits with rdata=wdata.
5. Spurious mem_done in IDLE, then reset_n pulsed low during MEM_WAIT -> outputs go to reset values; a subsequent read of 00110 misses (valid cleared).
6. With CACHE_STATS_EN defined, run scenarios 1-3 -> hit_count=2, miss_count=2. A bench forcing 300 hits -> hit_count=255.
